btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner.sv | 173 +++++++++++++++++
 tb/tb_btn_conditioner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, ms prescaler, per-button debounce, press/release pulses, optional auto-repeat (BTN_CONDITIONER_AUTOREPEAT_EN).
// Latency: level follows sync after DEBOUNCE_MS ticks, pulses one cycle after the level edge; no backpressure, outputs are free-running.
module btn_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int CLK_HZ          = 100000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 125
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic               ms_tick
);

    localparam int TICK_DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    DB_TGT    = 8'(DEBOUNCE_MS);

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [PW-1:0]      pre_cnt_q, pre_cnt_d;
    logic [7:0]         db_cnt_q [NUM_BTN];
    logic [7:0]         db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] level_prev_q, level_prev_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic               tick;

    assign tick = (pre_cnt_q == TICK_LAST);

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        pre_cnt_d    = tick ? '0 : pre_cnt_q + PW'(1);
        level_d      = level_q;
        level_prev_d = level_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            // Any cycle agreeing with the accepted level restarts the count.
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick) begin
                if (db_cnt_q[i] + 8'd1 == DB_TGT) begin
                    level_d[i]  = ~level_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
        press_d   = level_q & ~level_prev_q;
        release_d = ~level_q & level_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            pre_cnt_q    <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            release_q    <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            pre_cnt_q    <= pre_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
            release_q    <= release_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign ms_tick     = tick;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    typedef enum logic [1:0] {RP_IDLE, RP_DELAY, RP_RATE} rp_state_t;

    localparam logic [15:0] RP_DELAY_TGT = 16'(REPEAT_DELAY_MS);
    localparam logic [15:0] RP_RATE_TGT  = 16'(REPEAT_RATE_MS);

    rp_state_t          rp_st_q  [NUM_BTN];
    rp_state_t          rp_st_d  [NUM_BTN];
    logic [15:0]        rp_cnt_q [NUM_BTN];
    logic [15:0]        rp_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] repeat_q, repeat_d;

    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rp_st_d[i]  = rp_st_q[i];
            rp_cnt_d[i] = rp_cnt_q[i];
            // A released level wins over a repeat that would fire this cycle.
            if (!level_q[i]) begin
                rp_st_d[i]  = RP_IDLE;
                rp_cnt_d[i] = '0;
            end else begin
                case (rp_st_q[i])
                    RP_IDLE: begin
                        if (press_q[i]) begin
                            rp_st_d[i]  = RP_DELAY;
                            rp_cnt_d[i] = '0;
                        end
                    end
                    RP_DELAY: begin
                        if (tick) begin
                            if (rp_cnt_q[i] + 16'd1 == RP_DELAY_TGT) begin
                                repeat_d[i] = 1'b1;
                                rp_cnt_d[i] = '0;
                                rp_st_d[i]  = RP_RATE;
                            end else begin
                                rp_cnt_d[i] = rp_cnt_q[i] + 16'd1;
                            end
                        end
                    end
                    RP_RATE: begin
                        if (tick) begin
                            if (rp_cnt_q[i] + 16'd1 == RP_RATE_TGT) begin
                                repeat_d[i] = 1'b1;
                                rp_cnt_d[i] = '0;
                            end else begin
                                rp_cnt_d[i] = rp_cnt_q[i] + 16'd1;
                            end
                        end
                    end
                    default: begin
                        rp_st_d[i]  = RP_IDLE;
                        rp_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                rp_st_q[i]  <= RP_IDLE;
                rp_cnt_q[i] <= '0;
            end
        end else begin
            repeat_q <= repeat_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                rp_st_q[i]  <= rp_st_d[i];
                rp_cnt_q[i] <= rp_cnt_d[i];
            end
        end
    end

    assign btn_repeat = repeat_q;
`else
    assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected pulses with their cycle, a monitor pops them as the DUT pulses.
module tb_btn_conditioner;

    localparam int TICK_DIV = 10;
    localparam int DB       = 3;
    localparam int RP_DELAY = 5;
    localparam int RP_RATE  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = 5'b11111;
    logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
    logic       ms_tick;

    always #5 clk = ~clk;

    btn_conditioner #(
        .NUM_BTN        (5),
        .CLK_HZ         (10000),
        .DEBOUNCE_MS    (DB),
        .REPEAT_DELAY_MS(RP_DELAY),
        .REPEAT_RATE_MS (RP_RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .ms_tick    (ms_tick)
    );

    // cyc = cycles since the last edge that sampled rst; the prescaler equals cyc % TICK_DIV.
    int   cyc = 0;
    logic rst_seen = 1'b0;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) begin
        rst_seen <= rst;
        cyc      <= rst ? 0 : cyc + 1;
    end

    typedef struct {
        int         at;
        int         kind;   // 0 press, 1 release, 2 repeat
        logic [4:0] mask;
    } ev_t;

    ev_t exp_q[$];

    function automatic int nth_tick(int from, int n);
        int first;
        first = from + (TICK_DIV - 1 - from % TICK_DIV);
        return first + TICK_DIV * (n - 1);
    endfunction

    // Raw change at cycle c: sync at c+2, level flips after the DB-th tick, pulse one cycle later.
    function automatic int accept_pulse(int c);
        return nth_tick(c + 2, DB) + 2;
    endfunction

    task automatic expect_ev(int at, int kind, logic [4:0] mask);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [4:0] v;
        ev_t        e;
        if (rst_seen) mon_en = 1'b1;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_event: kind=%0d mask=%b due at cyc %0d, nothing seen by cyc %0d",
                         exp_q[0].kind, exp_q[0].mask, exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            chk("ms_tick", 32'(ms_tick), 32'(cyc % TICK_DIV == TICK_DIV - 1));
            if (rst_seen)
                chk("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat, ms_tick}), 32'd0);
            for (int k = 0; k < 3; k++) begin
                v = (k == 0) ? btn_press : (k == 1) ? btn_release : btn_repeat;
                if (v != 5'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse: kind=%0d got mask=%b at cyc %0d, none required", k, v, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.mask != v || e.at != cyc) begin
                            failures++;
                            $display("FAIL pulse: got kind=%0d mask=%b at cyc %0d, required kind=%0d mask=%b at cyc %0d",
                                     k, v, cyc, e.kind, e.mask, e.at);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, p, t, r;
        // Reset with every raw input high; the synchroniser must not capture them.
        repeat (4) @(negedge clk);
        rst     = 1'b0;
        btn_raw = 5'b00000;

        // Clean press and release on w.
        wait_cyc(3);
        c = cyc;
        btn_raw[0] = 1'b1;
        p = accept_pulse(c);
        expect_ev(p, 0, 5'b00001);
        wait_until(p - 2);
        chk("level_w_before_accept", 32'(btn_level), 32'd0);
        wait_until(p + 1);
        chk("level_w_after_press", 32'(btn_level), 32'h01);
        wait_until(p + 3);
        c = cyc;
        btn_raw[0] = 1'b0;
        t = accept_pulse(c);
        expect_ev(t, 1, 5'b00001);
        wait_until(t + 1);
        chk("level_w_after_release", 32'(btn_level), 32'd0);
        wait_cyc(5);

        // Bouncing s: high 15 / low 5 twice, then steady.
        for (int b = 0; b < 2; b++) begin
            btn_raw[2] = 1'b1;
            wait_cyc(15);
            btn_raw[2] = 1'b0;
            wait_cyc(5);
        end
        chk("level_s_after_bounce", 32'(btn_level), 32'd0);
        c = cyc;
        btn_raw[2] = 1'b1;
        p = accept_pulse(c);
        expect_ev(p, 0, 5'b00100);
        wait_until(p + 3);
        chk("level_s_held", 32'(btn_level), 32'h04);
        c = cyc;
        btn_raw[2] = 1'b0;
        t = accept_pulse(c);
        expect_ev(t, 1, 5'b00100);
        wait_until(t + 5);

        // Glitch on st shorter than a tick interval.
        btn_raw[4] = 1'b1;
        wait_cyc(8);
        btn_raw[4] = 1'b0;
        wait_cyc(40);
        chk("level_st_glitch", 32'(btn_level), 32'd0);

        // Long hold on a: repeats at 5, 7, 9, 11 ms, release before the next one.
        c = cyc;
        btn_raw[1] = 1'b1;
        p = accept_pulse(c);
        expect_ev(p, 0, 5'b00010);
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        r = nth_tick(p + 1, RP_DELAY) + 1;
        for (int n = 0; n < 4; n++) begin
            expect_ev(r, 2, 5'b00010);
            r = nth_tick(r, RP_RATE) + 1;
        end
`endif
        wait_until(p + 60);
        chk("level_a_held", 32'(btn_level), 32'h02);
        wait_until(p + 94);
        c = cyc;
        btn_raw[1] = 1'b0;
        t = accept_pulse(c);
        expect_ev(t, 1, 5'b00010);
        wait_until(t + 60);

        // Four buttons together, then a 1-cycle reset mid-hold.
        c = cyc;
        btn_raw[3:0] = 4'b1111;
        p = accept_pulse(c);
        expect_ev(p, 0, 5'b01111);
        wait_until(p + 1);
        chk("level_wasd_held", 32'(btn_level), 32'h0F);
        wait_until(p + 18);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("level_cleared_by_reset", 32'(btn_level), 32'd0);
        c = cyc;
        p = accept_pulse(c);
        expect_ev(p, 0, 5'b01111);
        wait_until(p + 3);
        c = cyc;
        btn_raw[3:0] = 4'b0000;
        t = accept_pulse(c);
        expect_ev(t, 1, 5'b01111);
        wait_until(t + 40);

        wait_cyc(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained: got %0d events left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
